// File: rtl/scan_capture_pkg.sv
// scan_capture_pkg: shared widths and FSM encoding for the scan frame capture block.
package scan_capture_pkg;
    localparam int WORD_W = 26;
    localparam int NUM_WORDS = 256;
    localparam int ADDR_W = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/scan_capture_ram.sv
// scan_capture_ram: paired x/w frame buffer, one write and one registered read port.
module scan_capture_ram
    import scan_capture_pkg::*;
#(
    parameter int W = WORD_W,
    parameter int DEPTH = NUM_WORDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_x,
    input  logic [W-1:0]      wr_w,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_x,
    output logic [W-1:0]      rd_w
);
    logic [2*W-1:0] mem [DEPTH];
    // Non-blocking read and write on the same edge give old data on a collision.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= {wr_w, wr_x};
        {rd_w, rd_x} <= mem[rd_addr];
    end
endmodule

// File: rtl/scan_frame_capture.sv
// scan_frame_capture: deserialises one x/w scan frame into a buffer while freezing the DUT.
// Optional XOR frame checksums are built only with SCAN_FRAME_CAPTURE_CSUM_EN defined.
module scan_frame_capture #(
    parameter int WORD_W = scan_capture_pkg::WORD_W,
    parameter int NUM_WORDS = scan_capture_pkg::NUM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_start,
    input  logic              scan_out_x,
    input  logic              scan_out_w,
    output logic              scan_en,
    output logic              scan_freeze,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_valid,
    input  logic [7:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data_x,
    output logic [WORD_W-1:0] rd_data_w,
    output logic [WORD_W-1:0] csum_x,
    output logic [WORD_W-1:0] csum_w
);
    import scan_capture_pkg::*;

    localparam int BW = $clog2(WORD_W);

    state_t state, state_nx;
    logic [BW-1:0] bit_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [WORD_W-2:0] acc_x, acc_w;
    logic [WORD_W-1:0] word_x, word_w;
    logic last_bit, we, start;

    assign last_bit = bit_idx == BW'(WORD_W - 1);
    assign we = state == SHIFT && last_bit;
    assign start = state == IDLE && scan_start;
    // The final bit goes straight into the stored word rather than the accumulator.
    assign word_x = {scan_out_x, acc_x};
    assign word_w = {scan_out_w, acc_w};
    assign busy = state != IDLE;

    always_comb begin
        state_nx = state == IDLE  ? (scan_start ? SHIFT : IDLE) :
                   state == SHIFT ? ((we && word_idx == '0) ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_idx     <= '0;
            word_idx    <= '0;
            acc_x       <= '0;
            acc_w       <= '0;
            scan_en     <= 1'b0;
            scan_freeze <= 1'b0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            scan_en     <= state_nx == SHIFT;
            scan_freeze <= state_nx != IDLE;
            frame_done  <= state_nx == DONE;
            if (start) begin
                bit_idx     <= '0;
                word_idx    <= ADDR_W'(NUM_WORDS - 1);
                frame_valid <= 1'b0;
            end else if (state == SHIFT) begin
                if (!last_bit) begin
                    acc_x[bit_idx] <= scan_out_x;
                    acc_w[bit_idx] <= scan_out_w;
                end
                bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
                if (last_bit) word_idx <= word_idx - 1'b1;
            end
            if (state_nx == DONE) frame_valid <= 1'b1;
        end
    end

`ifdef SCAN_FRAME_CAPTURE_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_x <= '0;
            csum_w <= '0;
        end else if (start) begin
            csum_x <= '0;
            csum_w <= '0;
        end else if (we) begin
            csum_x <= csum_x ^ word_x;
            csum_w <= csum_w ^ word_w;
        end
    end
`else
    assign csum_x = '0;
    assign csum_w = '0;
`endif

    scan_capture_ram #(.W(WORD_W), .DEPTH(NUM_WORDS)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (word_idx),
        .wr_x    (word_x),
        .wr_w    (word_w),
        .rd_addr (rd_addr),
        .rd_x    (rd_data_x),
        .rd_w    (rd_data_w)
    );
endmodule

// File: doc/scan_frame_capture.md
SCAN_FRAME_CAPTURE -- requirements
Module: scan_frame_capture

Interface
REQ-001 Parameter WORD_W, default 26, SHALL set the scan word width in bits.
REQ-002 Parameter NUM_WORDS, default 256, SHALL set the number of words per scan frame.
REQ-003 clk  input  1  SHALL be the single clock; all logic is posedge clk (the DUT mux_clk domain).
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 scan_start  input  1  SHALL request one frame capture, level-sampled in IDLE.
REQ-006 scan_out_x  input  1  SHALL carry the serial reference-sample chain bit, LSB first.
REQ-007 scan_out_w  input  1  SHALL carry the serial LMS-weight chain bit, LSB first.
REQ-008 scan_en  output  1  SHALL enable shifting of both DUT scan chains.
REQ-009 scan_freeze  output  1  SHALL freeze DUT adaptation while a capture is in progress.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 frame_done  output  1  SHALL pulse for one cycle when a complete frame is stored.
REQ-012 frame_valid  output  1  SHALL indicate that the buffer holds a complete frame.
REQ-013 rd_addr  input  8  SHALL be the buffer read address (word index).
REQ-014 rd_data_x  output  WORD_W  SHALL be the stored x word at rd_addr.
REQ-015 rd_data_w  output  WORD_W  SHALL be the stored w word at rd_addr.
REQ-016 csum_x  output  WORD_W  SHALL be the frame XOR checksum of the x words (see Configuration).
REQ-017 csum_w  output  WORD_W  SHALL be the frame XOR checksum of the w words (see Configuration).

Function
REQ-018 The FSM SHALL have three states: IDLE, SHIFT, and DONE.
REQ-019 In IDLE with scan_start=1, the next state SHALL be SHIFT; bit_idx SHALL load 0, word_idx SHALL load NUM_WORDS-1, and frame_valid SHALL clear.
REQ-020 scan_en SHALL be registered and high exactly in SHIFT; scan_freeze SHALL be high in SHIFT and DONE.
REQ-021 On every SHIFT cycle, the scan_out_x and scan_out_w bits SHALL be stored at position bit_idx of their accumulators (first bit to bit 0).
REQ-022 When bit_idx=WORD_W-1, each word written to the buffer at word_idx SHALL include the current (final) bit; bit_idx SHALL wrap to 0 and word_idx SHALL decrement.
REQ-023 When bit_idx=WORD_W-1 and word_idx=0, the next state SHALL be DONE; SHIFT SHALL therefore last exactly WORD_W*NUM_WORDS cycles (6656 at the defaults).
REQ-024 DONE SHALL last one cycle, during which frame_done=1 and frame_valid is set; the next state SHALL be IDLE.
REQ-025 scan_start in SHIFT or DONE SHALL be ignored; a start held high SHALL begin a new capture only on the cycle after DONE.
REQ-026 Buffer reads SHALL be synchronous with 1-cycle latency.
REQ-027 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-028 While rst_n=0: state=IDLE, scan_en=0, scan_freeze=0, busy=0, frame_done=0, frame_valid=0, csum_x=0, csum_w=0, and counters=0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the capture immediately with no frame_done; buffer contents are undefined until the next complete frame.

Configuration
REQ-030 With SCAN_FRAME_CAPTURE_CSUM_EN defined, the running XOR checksums SHALL clear on entry to SHIFT, accumulate each completed word, and be valid from the frame_done cycle until the next start.
REQ-031 Without SCAN_FRAME_CAPTURE_CSUM_EN, csum_x and csum_w SHALL be constant 0 and no checksum logic SHALL be synthesized; the ports SHALL remain.

Structure
REQ-032 Package scan_capture_pkg SHALL hold WORD_W, NUM_WORDS, and the FSM state enum.
REQ-033 Sub-module scan_capture_ram SHALL implement the dual WORD_W x NUM_WORDS single-write, single-read synchronous buffer.

Verification
REQ-034 Basic capture: reset, then pulse scan_start for one cycle, with the chains driving word k = k+1 (x) and ~k (w) LSB first, highest index first -> scan_en high for 6656 cycles, then one frame_done pulse; rd_addr=5 returns x=6 and w=~5 after one cycle.
REQ-035 Final-bit capture: every word = 26'h2000000 (only bit 25 set) -> all 256 stored words equal 26'h2000000.
REQ-036 Start while busy: scan_start high at cycle 100 of SHIFT -> no restart, and frame_done occurs at the nominal cycle; start held continuously -> a new SHIFT begins one cycle after DONE.
REQ-037 Reset mid-frame: deassert rst_n at cycle 3000 of SHIFT -> scan_en=0 and frame_valid=0 next edge, with no frame_done.
REQ-038 Checksum (macro defined): x words = 1..256 -> csum_x equals the XOR of 1..256 at frame_done; macro undefined -> csum_x = 0 throughout.
REQ-039 Read collision: read rd_addr=255 while word 255 of a second frame is being written -> first-frame data returned; a read one cycle later returns the second-frame data.
